// File: rtl/packet_switch_pkg.sv
`default_nettype none
// ============================================================
// Package : packet_switch_pkg
// Purpose : Shared egress constants, FSM state type and MAC segment record.
// Rev     : 1.0
// ============================================================
package packet_switch_pkg;

  localparam int PS_TDATA_WIDTH = 128;
  localparam int PS_NUM_SEG     = 2;
  localparam int PS_SEG_BYTES   = PS_TDATA_WIDTH / PS_NUM_SEG / 8;
  localparam int PS_EMPTY_WIDTH = $clog2(PS_SEG_BYTES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } egr_wadj_state_e;

  typedef struct packed {
    logic                      inframe;
    logic [PS_EMPTY_WIDTH-1:0] eop_empty;
    logic                      error;
  } MAC_TX_SEG_S;

  function automatic int seg_bytes(input int tdata_width, input int num_seg);
    return tdata_width / num_seg / 8;
  endfunction

  function automatic int empty_width(input int tdata_width, input int num_seg);
    return $clog2(seg_bytes(tdata_width, num_seg));
  endfunction

endpackage
`default_nettype wire

// File: rtl/egr_wadj_mac_seg_if_if.sv
`default_nettype none
// ============================================================
// Interface : egr_wadj_mac_seg_if_if
// Purpose   : Segmented AXI-Stream input, MAC segmented TX output, stat pulses.
// Rev       : 1.0
// ============================================================
interface egr_wadj_mac_seg_if_if #(
  parameter int EGR_TDATA_WIDTH    = 128,
  parameter int EGR_NUM_SEG        = 2,
  parameter int USERMETADATA_WIDTH = 1,
  parameter int EMPTY_WIDTH        = packet_switch_pkg::empty_width(EGR_TDATA_WIDTH, EGR_NUM_SEG)
);
  logic                            igr_tvalid;
  logic [EGR_TDATA_WIDTH-1:0]      igr_tdata;
  logic [EGR_TDATA_WIDTH/8-1:0]    igr_tkeep;
  logic                            igr_tlast;
  logic [EGR_NUM_SEG-1:0]          igr_tlast_segment;
  logic [USERMETADATA_WIDTH-1:0]   igr_tuser_usermetadata;
  logic                            igr_tready;

  logic                            mac_tx_valid;
  logic [EGR_TDATA_WIDTH-1:0]      mac_tx_data;
  logic [EGR_NUM_SEG-1:0]          mac_tx_inframe;
  logic [EGR_NUM_SEG*EMPTY_WIDTH-1:0] mac_tx_eop_empty;
  logic [EGR_NUM_SEG-1:0]          mac_tx_error;
  logic                            mac_tx_ready;

  logic                            stat_keep_err;
  logic                            stat_midpkt_gap;

  modport master (
    output igr_tvalid, igr_tdata, igr_tkeep, igr_tlast, igr_tlast_segment,
           igr_tuser_usermetadata, mac_tx_ready,
    input  igr_tready, mac_tx_valid, mac_tx_data, mac_tx_inframe,
           mac_tx_eop_empty, mac_tx_error, stat_keep_err, stat_midpkt_gap
  );

  modport slave (
    input  igr_tvalid, igr_tdata, igr_tkeep, igr_tlast, igr_tlast_segment,
           igr_tuser_usermetadata, mac_tx_ready,
    output igr_tready, mac_tx_valid, mac_tx_data, mac_tx_inframe,
           mac_tx_eop_empty, mac_tx_error, stat_keep_err, stat_midpkt_gap
  );
endinterface
`default_nettype wire

// File: rtl/egr_wadj_skid2.sv
`default_nettype none
// ============================================================
// Module  : egr_wadj_skid2
// Purpose : Generic 2-entry ready/valid skid buffer; head entry drives the output.
// Rev     : 1.0
// ============================================================
module egr_wadj_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             valid_q;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push      = in_valid & ready_q;
  assign pop       = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = head;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 2'd1;
    else if (pop && !push)
      count_nxt = count - 2'd1;
  end

  // Ready is registered from the post-move occupancy, so a full buffer never over-accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      head    <= '0;
      tail    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_nxt;
      valid_q <= (count_nxt != 2'd0);
      ready_q <= (count_nxt != 2'd2);
      if (pop) begin
        if (count == 2'd2) begin
          head <= tail;
          if (push)
            tail <= in_data;
        end else if (push) begin
          head <= in_data;
        end
      end else if (push) begin
        if (count == 2'd0)
          head <= in_data;
        else
          tail <= in_data;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/egr_wadj_mac_seg_if.sv
`default_nettype none
// ============================================================
// Module  : egr_wadj_mac_seg_if
// Purpose : Segmented AXI-Stream to MAC segmented TX adapter with keep checking.
// Rev     : 1.0
// ============================================================
module egr_wadj_mac_seg_if
  import packet_switch_pkg::*;
#(
  parameter int EGR_TDATA_WIDTH    = 128,
  parameter int EGR_NUM_SEG        = 2,
  parameter int EGR_SEG_WIDTH      = EGR_TDATA_WIDTH / EGR_NUM_SEG,
  parameter int USERMETADATA_WIDTH = 1,
  parameter int EMPTY_WIDTH        = $clog2(EGR_SEG_WIDTH / 8)
) (
  input logic                  clk,
  input logic                  rst,
  egr_wadj_mac_seg_if_if.slave bus
);
  localparam int SEG_BYTES     = EGR_SEG_WIDTH / 8;
  localparam int KEEP_WIDTH    = EGR_TDATA_WIDTH / 8;
  localparam int PAYLOAD_WIDTH = EGR_TDATA_WIDTH + EGR_NUM_SEG * (2 + EMPTY_WIDTH);

  logic [KEEP_WIDTH-1:0]              keep;
  logic [KEEP_WIDTH-1:0]              keep_plus1;
  logic [USERMETADATA_WIDTH-1:0]      meta;
  logic [SEG_BYTES-1:0]               eop_keep;
  logic                               keep_noncontig;
  logic                               keep_short;
  logic                               keep_above;
  logic                               keep_err;
  logic                               is_eop;
  logic                               contig_run;
  int                                 k_idx;
  int                                 e_idx;
  int                                 eop_idx;
  int                                 byte_cnt;
  logic [EGR_NUM_SEG-1:0]             inframe_d;
  logic [EGR_NUM_SEG-1:0]             error_d;
  logic [EGR_NUM_SEG*EMPTY_WIDTH-1:0] empty_d;
  logic [PAYLOAD_WIDTH-1:0]           in_payload;
  logic [PAYLOAD_WIDTH-1:0]           out_payload;
  logic                               accept;
  logic                               skid_ready;
  logic                               skid_valid;
  egr_wadj_state_e                    state;
  logic                               keep_err_pulse;
  logic                               gap_pulse;

  assign keep       = bus.igr_tkeep;
  assign meta       = bus.igr_tuser_usermetadata;
  assign keep_plus1 = keep + KEEP_WIDTH'(1);
  // A contiguous low-justified keep is 2^n-1, so adding one clears every set bit.
  assign keep_noncontig = |(keep & keep_plus1);

  always_comb begin
    k_idx      = 0;
    e_idx      = 0;
    keep_above = 1'b0;
    for (int i = 0; i < EGR_NUM_SEG; i++) begin
      if (|keep[i*SEG_BYTES +: SEG_BYTES]) k_idx = i;
      if (bus.igr_tlast_segment[i]) e_idx = i;
    end
    for (int i = 0; i < EGR_NUM_SEG; i++) begin
      if ((i > e_idx) && (|keep[i*SEG_BYTES +: SEG_BYTES])) keep_above = 1'b1;
    end
    keep_short = !bus.igr_tlast && !(&keep[(EGR_NUM_SEG-1)*SEG_BYTES +: SEG_BYTES]);
    keep_err   = keep_noncontig || keep_short || (bus.igr_tlast && keep_above);
    is_eop     = bus.igr_tlast || keep_err;
    eop_idx    = keep_err ? k_idx : e_idx;
    eop_keep   = keep[eop_idx*SEG_BYTES +: SEG_BYTES];

    // Malformed beats only count the unbroken run of low bytes.
    byte_cnt   = 0;
    contig_run = 1'b1;
    for (int j = 0; j < SEG_BYTES; j++) begin
      if (keep_err) begin
        contig_run = contig_run & eop_keep[j];
        if (contig_run) byte_cnt = byte_cnt + 1;
      end else if (eop_keep[j]) begin
        byte_cnt = byte_cnt + 1;
      end
    end

    inframe_d = '0;
    error_d   = '0;
    empty_d   = '0;
    for (int i = 0; i < EGR_NUM_SEG; i++) begin
      inframe_d[i] = is_eop ? (i < eop_idx) : (i <= k_idx);
      if (is_eop && (i == eop_idx)) begin
        empty_d[i*EMPTY_WIDTH +: EMPTY_WIDTH] = EMPTY_WIDTH'(SEG_BYTES - byte_cnt);
        error_d[i] = keep_err | meta[0];
      end
    end
  end

  assign accept     = bus.igr_tvalid & skid_ready;
  assign in_payload = {bus.igr_tdata, inframe_d, empty_d, error_d};

  egr_wadj_skid2 #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.igr_tvalid),
    .in_ready  (skid_ready),
    .in_data   (in_payload),
    .out_valid (skid_valid),
    .out_ready (bus.mac_tx_ready),
    .out_data  (out_payload)
  );

  assign bus.igr_tready   = skid_ready;
  assign bus.mac_tx_valid = skid_valid;
  assign {bus.mac_tx_data, bus.mac_tx_inframe, bus.mac_tx_eop_empty, bus.mac_tx_error} = out_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      keep_err_pulse <= 1'b0;
      gap_pulse      <= 1'b0;
    end else begin
      keep_err_pulse <= accept & keep_err;
      gap_pulse      <= (state == ST_IN_PKT) & !bus.igr_tvalid;
      if (accept)
        state <= is_eop ? ST_IDLE : ST_IN_PKT;
    end
  end

  assign bus.stat_keep_err   = keep_err_pulse;
  assign bus.stat_midpkt_gap = gap_pulse;
endmodule
`default_nettype wire

// File: tb/tb_egr_wadj_mac_seg_if.sv
`default_nettype none
// ============================================================
// Module  : tb_egr_wadj_mac_seg_if
// Purpose : Scoreboard bench for the egress MAC segment adapter (2 x 64-bit segments).
// Rev     : 1.0
// ============================================================
module tb_egr_wadj_mac_seg_if;
  localparam int TDW = 128;
  localparam int NSEG = 2;
  localparam int EW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  egr_wadj_mac_seg_if_if #(
    .EGR_TDATA_WIDTH(TDW), .EGR_NUM_SEG(NSEG), .USERMETADATA_WIDTH(1), .EMPTY_WIDTH(EW)
  ) bus ();

  egr_wadj_mac_seg_if #(
    .EGR_TDATA_WIDTH(TDW), .EGR_NUM_SEG(NSEG), .EGR_SEG_WIDTH(TDW/NSEG),
    .USERMETADATA_WIDTH(1), .EMPTY_WIDTH(EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [127:0] data;
    logic [1:0]   inframe;
    logic [5:0]   empty;
    logic [1:0]   error;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int exp_gap = 0;
  int exp_kerr = 0;
  int got_gap = 0;
  int got_kerr = 0;
  int rdy_low = 0;
  int rdy_mode = 2;
  bit in_pkt = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a beat carrying nbytes low-justified bytes; a short non-last beat is malformed.
  function automatic exp_t model(input logic [127:0] d, input int nbytes, input bit last, input bit meta);
    exp_t x;
    int e;
    x.data = d;
    x.inframe = 2'b00;
    x.empty = 6'd0;
    x.error = 2'b00;
    if (!last && nbytes == 16) begin
      x.inframe = 2'b11;
    end else begin
      e = (nbytes - 1) / 8;
      x.inframe = 2'((1 << e) - 1);
      x.empty = 6'((8 * (e + 1) - nbytes) << (3 * e));
      x.error = (meta || !last) ? 2'(1 << e) : 2'b00;
    end
    return x;
  endfunction

  task automatic send_raw(input logic [15:0] keep, input bit last, input logic [1:0] lseg,
                          input bit meta, input exp_t x, input bit kerr);
    int waited = 0;
    bus.igr_tdata = x.data;
    bus.igr_tkeep = keep;
    bus.igr_tlast = last;
    bus.igr_tlast_segment = lseg;
    bus.igr_tuser_usermetadata = meta;
    bus.igr_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.igr_tready) break;
      waited++;
      if (waited > 1000) begin
        chk("igr_tready_timeout", 0, 1);
        bus.igr_tvalid = 1'b0;
        return;
      end
    end
    sb.push_back(x);
    if (kerr) exp_kerr++;
    in_pkt = !(last || kerr);
    @(posedge clk);
    #1;
    bus.igr_tvalid = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] d, input int nbytes, input bit last, input bit meta);
    logic [15:0] keep;
    logic [1:0] lseg;
    keep = 16'((32'd1 << nbytes) - 1);
    lseg = !last ? 2'b00 : (nbytes > 8 ? 2'b10 : 2'b01);
    send_raw(keep, last, lseg, meta, model(d, nbytes, last, meta), !last && nbytes < 16);
  endtask

  task automatic idle(input int n);
    if (in_pkt) exp_gap += n;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_pkt(input int len, input bit meta, input int err_at, input bit gaps);
    int b = 0;
    int rem = len;
    while (rem > 0) begin
      if (b == err_at && rem > 16) begin
        send_bytes(rnd128(), $urandom_range(1, 15), 1'b0, meta);
        return;
      end
      send_bytes(rnd128(), (rem > 16) ? 16 : rem, rem <= 16, meta);
      rem -= 16;
      b++;
      if (rem > 0 && gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 0);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.mac_tx_ready = 1'($urandom_range(0, 1));
      1:       bus.mac_tx_ready = 1'b1;
      2:       bus.mac_tx_ready = 1'b0;
      default: bus.mac_tx_ready = ~bus.mac_tx_ready;
    endcase
  end

  // Monitor: pops one expectation per output transfer.
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (bus.stat_midpkt_gap) got_gap++;
      if (bus.stat_keep_err) got_kerr++;
      if (!bus.igr_tready) rdy_low++;
      if (bus.mac_tx_valid && bus.mac_tx_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("data", bus.mac_tx_data, x.data);
          chk("inframe", 128'(bus.mac_tx_inframe), 128'(x.inframe));
          chk("eop_empty", 128'(bus.mac_tx_eop_empty), 128'(x.empty));
          chk("error", 128'(bus.mac_tx_error), 128'(x.error));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.igr_tvalid = 1'b0;
    bus.igr_tdata = '0;
    bus.igr_tkeep = '0;
    bus.igr_tlast = 1'b0;
    bus.igr_tlast_segment = '0;
    bus.igr_tuser_usermetadata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 128'(bus.igr_tready), 0);
    chk("rst_valid", 128'(bus.mac_tx_valid), 0);
    chk("rst_inframe", 128'(bus.mac_tx_inframe), 0);
    chk("rst_empty", 128'(bus.mac_tx_eop_empty), 0);
    chk("rst_error", 128'(bus.mac_tx_error), 0);
    chk("rst_stats", 128'({bus.stat_keep_err, bus.stat_midpkt_gap}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("tready_after_rst", 128'(bus.igr_tready), 1);
    @(posedge clk);
    #1;

    // One full beat: output must be valid one cycle after acceptance.
    send_bytes(rnd128(), 16, 1'b1, 1'b0);
    @(negedge clk);
    chk("latency_valid", 128'(bus.mac_tx_valid), 1);
    @(posedge clk);
    #1;
    send_bytes(rnd128(), 13, 1'b1, 1'b0);
    send_bytes(rnd128(), 16, 1'b0, 1'b1);
    idle(2);
    send_bytes(rnd128(), 16, 1'b0, 1'b1);
    send_bytes(rnd128(), 8, 1'b1, 1'b1);
    drain();

    // Alternating MAC ready with continuous input must back-pressure without loss.
    rdy_mode = 3;
    base = rdy_low;
    send_pkt(128, 1'b0, -1, 1'b0);
    drain();
    chk("backpressure_seen", 128'((rdy_low - base) > 0), 1);
    rdy_mode = 1;

    // Short mid-packet beat, then a fresh SOP.
    send_bytes(rnd128(), 16, 1'b0, 1'b0);
    send_bytes(rnd128(), 8, 1'b0, 1'b0);
    send_bytes(rnd128(), 8, 1'b1, 1'b0);
    begin
      exp_t x;
      x.data = rnd128();
      x.inframe = 2'b01; x.empty = 6'b011_000; x.error = 2'b10;
      send_raw(16'h5FFF, 1'b1, 2'b10, 1'b0, x, 1'b1);
      x.data = rnd128();
      x.inframe = 2'b01; x.empty = 6'b100_000; x.error = 2'b10;
      send_raw(16'h0FFF, 1'b1, 2'b01, 1'b0, x, 1'b1);
    end
    drain();

    rdy_mode = 0;
    for (int p = 0; p < 40; p++) begin
      send_pkt($urandom_range(1, 80), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : -1, 1'b1);
      idle($urandom_range(0, 2));
    end
    rdy_mode = 1;
    drain();

    // Reset with two beats parked in the buffer: they must never appear.
    rdy_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send_bytes(rnd128(), 16, 1'b0, 1'b0);
    send_bytes(rnd128(), 16, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    in_pkt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 128'(bus.mac_tx_valid), 0);
    chk("midrst_inframe", 128'(bus.mac_tx_inframe), 0);
    chk("midrst_error", 128'(bus.mac_tx_error), 0);
    chk("midrst_tready", 128'(bus.igr_tready), 0);
    @(posedge clk);
    #1;
    rdy_mode = 1;
    send_bytes(rnd128(), 8, 1'b1, 1'b1);
    drain();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("gap_pulses", 128'(got_gap), 128'(exp_gap));
    chk("keep_err_pulses", 128'(got_kerr), 128'(exp_kerr));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
